// File: rtl/cpu_common_pkg.sv
// Shared CPU types: memory operation codes, exception payload and the
// data-cache requester state encoding (exported for waveform/debug reuse).
package cpu_common;

    localparam int unsigned EXC_CAUSE_W = 5;
    localparam int unsigned EXC_TVAL_W  = 64;

    typedef enum logic [2:0] {
        MEM_LOAD  = 3'd0,
        MEM_STORE = 3'd1,
        MEM_LR    = 3'd2,
        MEM_SC    = 3'd3,
        MEM_AMO   = 3'd4
    } mem_op_t;

    typedef struct packed {
        logic                   valid;
        logic [EXC_CAUSE_W-1:0] cause;
        logic [EXC_TVAL_W-1:0]  tval;
    } exception_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        NOTIF = 3'd4
    } dcache_req_state_e;

endpackage

// File: rtl/dcache_intf.sv
// Core <-> data-cache channel: request, response (no backpressure) and
// SFENCE/SATP notification handshakes.
interface dcache_intf
    import cpu_common::*;
#(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_address;
    logic [XLEN-1:0] req_value;
    mem_op_t         req_op;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [6:0]      req_amo;
    logic            req_prv;
    logic            req_sum;
    logic            req_mxr;
    logic [XLEN-1:0] req_atp;

    logic            resp_valid;
    logic [XLEN-1:0] resp_value;
    exception_t      resp_exception;

    logic            notif_valid;
    logic            notif_reason;
    logic            notif_ready;

    modport user (
        output req_valid, req_address, req_value, req_op, req_size, req_unsigned,
               req_amo, req_prv, req_sum, req_mxr, req_atp,
        input  req_ready,
        input  resp_valid, resp_value, resp_exception,
        output notif_valid, notif_reason,
        input  notif_ready
    );

    modport provider (
        input  req_valid, req_address, req_value, req_op, req_size, req_unsigned,
               req_amo, req_prv, req_sum, req_mxr, req_atp,
        output req_ready,
        output resp_valid, resp_value, resp_exception,
        input  notif_valid, notif_reason,
        output notif_ready
    );

endinterface

// File: rtl/dcache_requester.sv
// Pipeline-side initiator for the data cache: one operation in flight,
// response buffered until consumed, SFENCE/SATP notifications serialised.
module dcache_requester
    import cpu_common::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            pipe_req_valid,
    output logic            pipe_req_ready,
    input  logic [XLEN-1:0] pipe_req_address,
    input  logic [XLEN-1:0] pipe_req_value,
    input  mem_op_t         pipe_req_op,
    input  logic [1:0]      pipe_req_size,
    input  logic            pipe_req_unsigned,
    input  logic [6:0]      pipe_req_amo,
    input  logic            csr_prv,
    input  logic            csr_sum,
    input  logic            csr_mxr,
    input  logic [XLEN-1:0] csr_atp,
    output logic            pipe_resp_valid,
    input  logic            pipe_resp_ready,
    output logic [XLEN-1:0] pipe_resp_value,
    output exception_t      pipe_resp_exception,
    input  logic            flush,
    input  logic            sfence_valid,
    input  logic            sfence_reason,
    output logic            sfence_ready,
    output logic            busy,
    dcache_intf.user        dcache
);

    dcache_req_state_e state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic              notif_valid_q, notif_valid_d;
    logic              notif_reason_q, notif_reason_d;
    logic              pipe_resp_valid_q, pipe_resp_valid_d;
    logic              sfence_ready_q, sfence_ready_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   value_q, value_d;
    mem_op_t           op_q, op_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [6:0]        amo_q, amo_d;
    logic              prv_q, prv_d;
    logic              sum_q, sum_d;
    logic              mxr_q, mxr_d;
    logic [XLEN-1:0]   atp_q, atp_d;
    logic [XLEN-1:0]   resp_value_q, resp_value_d;
    exception_t        resp_exc_q, resp_exc_d;
    logic              resp_take;

    assign pipe_req_ready = (state_q == IDLE) && !sfence_valid;
    // A response is only legal once the request has been (or is being) accepted.
    assign resp_take = dcache.resp_valid &&
                       ((state_q == WAIT) || ((state_q == REQ) && dcache.req_ready));

    always_comb begin
        state_d           = state_q;
        req_valid_d       = req_valid_q;
        notif_valid_d     = notif_valid_q;
        notif_reason_d    = notif_reason_q;
        pipe_resp_valid_d = pipe_resp_valid_q;
        sfence_ready_d    = 1'b0;
        drop_d            = drop_q;
        addr_d            = addr_q;
        value_d           = value_q;
        op_d              = op_q;
        size_d            = size_q;
        unsigned_d        = unsigned_q;
        amo_d             = amo_q;
        prv_d             = prv_q;
        sum_d             = sum_q;
        mxr_d             = mxr_q;
        atp_d             = atp_q;
        resp_value_d      = resp_value_q;
        resp_exc_d        = resp_exc_q;

        case (state_q)
            IDLE: begin
                // sfence_ready_q masks the notification that just completed.
                if (sfence_valid && !sfence_ready_q) begin
                    state_d        = NOTIF;
                    notif_valid_d  = 1'b1;
                    notif_reason_d = sfence_reason;
                end else if (pipe_req_valid && pipe_req_ready) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    drop_d      = 1'b0;
                    addr_d      = pipe_req_address;
                    value_d     = pipe_req_value;
                    op_d        = pipe_req_op;
                    size_d      = pipe_req_size;
                    unsigned_d  = pipe_req_unsigned;
                    amo_d       = pipe_req_amo;
                    prv_d       = csr_prv;
                    sum_d       = csr_sum;
                    mxr_d       = csr_mxr;
                    atp_d       = csr_atp;
                end
            end
            REQ: begin
                if (flush) drop_d = 1'b1;
                if (dcache.req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (flush) drop_d = 1'b1;
            end
            RESP: begin
                if (pipe_resp_ready || flush) begin
                    pipe_resp_valid_d = 1'b0;
                    state_d           = IDLE;
                end
            end
            NOTIF: begin
                if (dcache.notif_ready) begin
                    notif_valid_d  = 1'b0;
                    sfence_ready_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flushed operations still complete on the cache side; only the result is discarded.
        if (resp_take) begin
            resp_value_d = dcache.resp_value;
            resp_exc_d   = dcache.resp_exception;
            if (drop_q || flush) begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end else begin
                state_d           = RESP;
                pipe_resp_valid_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= IDLE;
            req_valid_q       <= 1'b0;
            notif_valid_q     <= 1'b0;
            notif_reason_q    <= 1'b0;
            pipe_resp_valid_q <= 1'b0;
            sfence_ready_q    <= 1'b0;
            busy_q            <= 1'b0;
            drop_q            <= 1'b0;
            addr_q            <= '0;
            value_q           <= '0;
            op_q              <= MEM_LOAD;
            size_q            <= '0;
            unsigned_q        <= 1'b0;
            amo_q             <= '0;
            prv_q             <= 1'b0;
            sum_q             <= 1'b0;
            mxr_q             <= 1'b0;
            atp_q             <= '0;
            resp_value_q      <= '0;
            resp_exc_q        <= '0;
        end else begin
            state_q           <= state_d;
            req_valid_q       <= req_valid_d;
            notif_valid_q     <= notif_valid_d;
            notif_reason_q    <= notif_reason_d;
            pipe_resp_valid_q <= pipe_resp_valid_d;
            sfence_ready_q    <= sfence_ready_d;
            busy_q            <= busy_d;
            drop_q            <= drop_d;
            addr_q            <= addr_d;
            value_q           <= value_d;
            op_q              <= op_d;
            size_q            <= size_d;
            unsigned_q        <= unsigned_d;
            amo_q             <= amo_d;
            prv_q             <= prv_d;
            sum_q             <= sum_d;
            mxr_q             <= mxr_d;
            atp_q             <= atp_d;
            resp_value_q      <= resp_value_d;
            resp_exc_q        <= resp_exc_d;
        end
    end

    assign dcache.req_valid    = req_valid_q;
    assign dcache.req_address  = addr_q;
    assign dcache.req_value    = value_q;
    assign dcache.req_op       = op_q;
    assign dcache.req_size     = size_q;
    assign dcache.req_unsigned = unsigned_q;
    assign dcache.req_amo      = amo_q;
    assign dcache.req_prv      = prv_q;
    assign dcache.req_sum      = sum_q;
    assign dcache.req_mxr      = mxr_q;
    assign dcache.req_atp      = atp_q;
    assign dcache.notif_valid  = notif_valid_q;
    assign dcache.notif_reason = notif_reason_q;

    assign pipe_resp_valid     = pipe_resp_valid_q;
    assign pipe_resp_value     = resp_value_q;
    assign pipe_resp_exception = resp_exc_q;
    assign sfence_ready        = sfence_ready_q;
    assign busy                = busy_q;

    // The cache has no response backpressure, so a response outside an access is a protocol bug.
    resp_only_when_expected: assert property (@(posedge clk) disable iff (!rstn)
        dcache.resp_valid |-> ((state_q == WAIT) || ((state_q == REQ) && dcache.req_ready)));

endmodule

// File: tb/tb_dcache_requester.sv
// Bench for dcache_requester: scripted cache provider plus request/response
// scoreboards filled when stimulus is driven and drained when the DUT answers.
module tb_dcache_requester;
    import cpu_common::*;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] value;
        mem_op_t     op;
        logic [1:0]  size;
        logic        uns;
        logic [6:0]  amo;
        logic        prv;
        logic        sum;
        logic        mxr;
        logic [63:0] atp;
    } exp_req_t;

    typedef struct packed {
        logic [63:0] value;
        exception_t  exc;
    } exp_resp_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            pipe_req_valid;
    logic            pipe_req_ready;
    logic [XLEN-1:0] pipe_req_address;
    logic [XLEN-1:0] pipe_req_value;
    mem_op_t         pipe_req_op;
    logic [1:0]      pipe_req_size;
    logic            pipe_req_unsigned;
    logic [6:0]      pipe_req_amo;
    logic            csr_prv, csr_sum, csr_mxr;
    logic [XLEN-1:0] csr_atp;
    logic            pipe_resp_valid;
    logic            pipe_resp_ready;
    logic [XLEN-1:0] pipe_resp_value;
    exception_t      pipe_resp_exception;
    logic            flush;
    logic            sfence_valid;
    logic            sfence_reason;
    logic            sfence_ready;
    logic            busy;

    dcache_intf #(.XLEN(XLEN)) dc ();

    dcache_requester #(.XLEN(XLEN)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .pipe_req_valid      (pipe_req_valid),
        .pipe_req_ready      (pipe_req_ready),
        .pipe_req_address    (pipe_req_address),
        .pipe_req_value      (pipe_req_value),
        .pipe_req_op         (pipe_req_op),
        .pipe_req_size       (pipe_req_size),
        .pipe_req_unsigned   (pipe_req_unsigned),
        .pipe_req_amo        (pipe_req_amo),
        .csr_prv             (csr_prv),
        .csr_sum             (csr_sum),
        .csr_mxr             (csr_mxr),
        .csr_atp             (csr_atp),
        .pipe_resp_valid     (pipe_resp_valid),
        .pipe_resp_ready     (pipe_resp_ready),
        .pipe_resp_value     (pipe_resp_value),
        .pipe_resp_exception (pipe_resp_exception),
        .flush               (flush),
        .sfence_valid        (sfence_valid),
        .sfence_reason       (sfence_reason),
        .sfence_ready        (sfence_ready),
        .busy                (busy),
        .dcache              (dc.user)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int req_hs   = 0;
    exp_req_t  req_q[$];
    exp_resp_t resp_q[$];

    always @(posedge clk) if (dc.req_valid && dc.req_ready) req_hs <= req_hs + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_req_t cur_req();
        return '{dc.req_address, dc.req_value, dc.req_op, dc.req_size, dc.req_unsigned,
                 dc.req_amo, dc.req_prv, dc.req_sum, dc.req_mxr, dc.req_atp};
    endfunction

    // Offer one operation until accepted; inputs are scrambled afterwards so held fields are checked.
    task automatic send_req(input mem_op_t op, input logic [63:0] addr, input logic [63:0] val,
                            input logic [1:0] size, input logic uns, input logic [6:0] amo);
        exp_req_t e;
        bit done = 0;
        pipe_req_valid = 1'b1;  pipe_req_op = op;  pipe_req_address = addr;
        pipe_req_value = val;   pipe_req_size = size;  pipe_req_unsigned = uns;
        pipe_req_amo = amo;
        csr_prv = 1'($urandom); csr_sum = 1'($urandom); csr_mxr = 1'($urandom);
        csr_atp = {$urandom, $urandom};
        e = '{addr, val, op, size, uns, amo, csr_prv, csr_sum, csr_mxr, csr_atp};
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (pipe_req_ready) done = 1;
            tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept: pipe_req_ready never rose within 20 cycles (actual 0, required 1)");
        end else req_q.push_back(e);
        pipe_req_valid = 1'b0;
        pipe_req_address = {$urandom, $urandom}; pipe_req_value = {$urandom, $urandom};
        pipe_req_size = 2'($urandom); pipe_req_amo = 7'($urandom);
        csr_prv = ~csr_prv; csr_atp = ~csr_atp;
    endtask

    // Cache provider: hold req_ready low req_wait cycles, respond resp_delay cycles after accept.
    task automatic cache_serve(input int req_wait, input int resp_delay, input logic [63:0] rv,
                               input exception_t exc, input bit flush_wait);
        exp_req_t e;
        exp_req_t a;
        int k = 0;
        int skip;
        while (!dc.req_valid && k < 20) begin tick(); k++; end
        n_checks++;
        if (!dc.req_valid || req_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_timeout: req_valid=%0b pending=%0d (required req_valid 1)",
                     dc.req_valid, req_q.size());
        end else begin
            e = req_q.pop_front();
            for (int i = 0; i <= req_wait; i++) begin
                a = cur_req();
                n_checks++;
                if (!dc.req_valid || a !== e) begin
                    n_fail++;
                    $display("FAIL req_fields cycle %0d: valid=%0b got %h required %h",
                             i, dc.req_valid, a, e);
                end
                if (i == req_wait) begin
                    dc.req_ready = 1'b1;
                    if (resp_delay == 0) begin
                        dc.resp_valid = 1'b1; dc.resp_value = rv; dc.resp_exception = exc;
                    end
                end
                tick();
            end
            dc.req_ready  = 1'b0;
            dc.resp_valid = 1'b0;
            if (resp_delay > 0) begin
                n_checks++;
                if (dc.req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_release: req_valid=%0b required 0", dc.req_valid);
                end
                if (flush_wait) begin flush = 1'b1; tick(); flush = 1'b0; end
                skip = flush_wait ? 2 : 1;
                for (int i = skip; i < resp_delay; i++) tick();
                dc.resp_valid = 1'b1; dc.resp_value = rv; dc.resp_exception = exc;
                tick();
                dc.resp_valid = 1'b0;
            end
            if (!flush_wait) resp_q.push_back('{rv, exc});
        end
    endtask

    // Pipeline consumer: expects the response now, stalls 'hold' cycles, then takes it.
    task automatic pipe_take(input int hold);
        exp_resp_t e;
        exp_resp_t a;
        n_checks++;
        if (pipe_resp_valid !== 1'b1 || resp_q.size() == 0) begin
            n_fail++;
            $display("FAIL resp_latency: pipe_resp_valid=%0b pending=%0d (required 1)",
                     pipe_resp_valid, resp_q.size());
            return;
        end
        e = resp_q.pop_front();
        a = '{pipe_resp_value, pipe_resp_exception};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL resp_data: got %h required %h", a, e);
        end
        for (int i = 0; i < hold; i++) begin
            n_checks++;
            if (pipe_req_ready !== 1'b0 || pipe_resp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL resp_hold %0d: req_ready=%0b resp_valid=%0b required 0/1",
                         i, pipe_req_ready, pipe_resp_valid);
            end
            tick();
        end
        pipe_resp_ready = 1'b1;
        tick();
        pipe_resp_ready = 1'b0;
        n_checks++;
        if (pipe_resp_valid !== 1'b0 || busy !== 1'b0 || pipe_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_release: resp_valid=%0b busy=%0b req_ready=%0b required 0/0/1",
                     pipe_resp_valid, busy, pipe_req_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        n_checks++;
        if ({dc.req_valid, dc.notif_valid, pipe_resp_valid, sfence_ready, busy} !== 5'b0 ||
            pipe_resp_value !== '0 || pipe_resp_exception !== '0 || dc.req_address !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b value=%h exc=%h addr=%h required all 0",
                     {dc.req_valid, dc.notif_valid, pipe_resp_valid, sfence_ready, busy},
                     pipe_resp_value, pipe_resp_exception, dc.req_address);
        end
        #2 rstn = 1'b1;
        tick();
        n_checks++;
        if (pipe_req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req_ready=%0b busy=%0b required 1/0", pipe_req_ready, busy);
        end
    endtask

    task automatic test_load();
        send_req(MEM_LOAD, 64'h1000, 64'h0, 2'b11, 1'b0, 7'h0);
        n_checks++;
        if (dc.req_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL req_latency: req_valid=%0b busy=%0b required 1/1", dc.req_valid, busy);
        end
        cache_serve(2, 3, 64'hDEADBEEF, '0, 1'b0);
        pipe_take(0);
    endtask

    task automatic test_back_to_back();
        int hs0 = req_hs;
        send_req(MEM_STORE, 64'h2000, 64'h1122334455667788, 2'b10, 1'b0, 7'h0);
        cache_serve(0, 1, 64'h0, '0, 1'b0);
        pipe_req_valid = 1'b1; pipe_req_op = MEM_LOAD; pipe_req_address = 64'h2000;
        pipe_take(5);
        send_req(MEM_LOAD, 64'h2000, 64'h0, 2'b10, 1'b1, 7'h0);
        cache_serve(1, 2, 64'h0000000055667788, '0, 1'b0);
        pipe_take(0);
        n_checks++;
        if (req_hs - hs0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d cache requests, required 2", req_hs - hs0);
        end
    endtask

    task automatic test_flush();
        int hs0 = req_hs;
        exp_resp_t e;
        send_req(MEM_LOAD, 64'h3000, 64'h0, 2'b11, 1'b0, 7'h0);
        cache_serve(0, 3, 64'hCAFEF00D, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (pipe_resp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_drop %0d: resp_valid=%0b busy=%0b required 0/0",
                         i, pipe_resp_valid, busy);
            end
            tick();
        end
        n_checks++;
        if (req_hs - hs0 !== 1 || resp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_count: %0d cache requests, %0d pending responses, required 1/0",
                     req_hs - hs0, resp_q.size());
        end
        // Next operation accepted; this time flushed while the response is buffered.
        send_req(MEM_LR, 64'h3008, 64'h0, 2'b11, 1'b0, 7'h0);
        cache_serve(0, 1, 64'h0123456789ABCDEF, '0, 1'b0);
        n_checks++;
        if (pipe_resp_valid !== 1'b1 || resp_q.size() == 0) begin
            n_fail++;
            $display("FAIL flush_next: resp_valid=%0b required 1", pipe_resp_valid);
        end else begin
            e = resp_q.pop_front();
            n_checks++;
            if (pipe_resp_value !== e.value) begin
                n_fail++;
                $display("FAIL flush_next_data: got %h required %h", pipe_resp_value, e.value);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (pipe_resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resp: resp_valid=%0b busy=%0b required 0/0", pipe_resp_valid, busy);
        end
    endtask

    task automatic test_sfence();
        sfence_valid = 1'b1; sfence_reason = 1'b1;
        pipe_req_valid = 1'b1; pipe_req_op = MEM_STORE;
        #1;
        n_checks++;
        if (pipe_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sfence_prio: pipe_req_ready=%0b required 0", pipe_req_ready);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({dc.notif_valid, dc.notif_reason, dc.req_valid, busy} !== 4'b1101) begin
                n_fail++;
                $display("FAIL notif_hold %0d: notif_valid/reason/req_valid/busy=%b required 1101",
                         i, {dc.notif_valid, dc.notif_reason, dc.req_valid, busy});
            end
            if (i == 2) dc.notif_ready = 1'b1;
            tick();
        end
        dc.notif_ready = 1'b0;
        n_checks++;
        if ({sfence_ready, dc.notif_valid, pipe_req_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL sfence_done: sfence_ready/notif_valid/req_ready=%b required 100",
                     {sfence_ready, dc.notif_valid, pipe_req_ready});
        end
        sfence_valid = 1'b0;
        send_req(MEM_STORE, 64'h4000, 64'hA5A5A5A5A5A5A5A5, 2'b11, 1'b0, 7'h0);
        n_checks++;
        if ({sfence_ready, dc.notif_valid, dc.req_valid} !== 3'b001) begin
            n_fail++;
            $display("FAIL sfence_after: sfence_ready/notif_valid/req_valid=%b required 001",
                     {sfence_ready, dc.notif_valid, dc.req_valid});
        end
        cache_serve(0, 1, 64'h0, '0, 1'b0);
        pipe_take(0);
    endtask

    task automatic test_amo_exception();
        exception_t exc;
        exc = '{valid: 1'b1, cause: 5'd15, tval: 64'h5008};
        send_req(MEM_AMO, 64'h5008, 64'h7, 2'b11, 1'b0, 7'b0000011);
        cache_serve(1, 0, 64'h0, exc, 1'b0);
        pipe_take(1);
    endtask

    task automatic test_reset_mid_wait();
        exp_req_t e;
        exp_req_t a;
        send_req(MEM_LOAD, 64'h6000, 64'h0, 2'b01, 1'b1, 7'h0);
        e = req_q.pop_front();
        a = cur_req();
        n_checks++;
        if (dc.req_valid !== 1'b1 || a !== e) begin
            n_fail++;
            $display("FAIL rst_req: valid=%0b got %h required %h", dc.req_valid, a, e);
        end
        dc.req_ready = 1'b1;
        tick();
        dc.req_ready = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({dc.req_valid, dc.notif_valid, pipe_resp_valid, sfence_ready, busy} !== 5'b0 ||
            dc.req_address !== '0) begin
            n_fail++;
            $display("FAIL rst_async: ctl=%b addr=%h required 0",
                     {dc.req_valid, dc.notif_valid, pipe_resp_valid, sfence_ready, busy},
                     dc.req_address);
        end
        dc.resp_valid = 1'b1; dc.resp_value = 64'h5555AAAA5555AAAA;
        tick(); tick();
        dc.resp_valid = 1'b0;
        #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pipe_resp_valid !== 1'b0 || busy !== 1'b0 || pipe_resp_value !== '0) begin
                n_fail++;
                $display("FAIL rst_stray %0d: resp_valid=%0b busy=%0b value=%h required 0",
                         i, pipe_resp_valid, busy, pipe_resp_value);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        pipe_req_valid = 1'b0; pipe_req_address = '0; pipe_req_value = '0;
        pipe_req_op = MEM_LOAD; pipe_req_size = '0; pipe_req_unsigned = 1'b0; pipe_req_amo = '0;
        csr_prv = 1'b0; csr_sum = 1'b0; csr_mxr = 1'b0; csr_atp = '0;
        pipe_resp_ready = 1'b0; flush = 1'b0; sfence_valid = 1'b0; sfence_reason = 1'b0;
        dc.req_ready = 1'b0; dc.resp_valid = 1'b0; dc.resp_value = '0;
        dc.resp_exception = '0; dc.notif_ready = 1'b0;

        test_reset();
        test_load();
        test_back_to_back();
        test_flush();
        test_sfence();
        test_amo_exception();
        test_reset_mid_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
